// File: rtl/sqrl_jtag_pkg.sv
// Shared constants for the JTAG byte/word stream: DR frame layout and
// synchroniser bit positions.
package sqrl_jtag_pkg;

    // Offsets above the DATA_W-bit data field of the DR frame.
    localparam int unsigned FRAME_ACK_BIT            = 0;  // update frame: host_ack
    localparam int unsigned FRAME_VALID_BIT          = 1;  // update frame: host_valid
    localparam int unsigned FRAME_STATUS_TXAVAIL_BIT = 0;  // capture frame: tx_avail
    localparam int unsigned FRAME_STATUS_RXSPACE_BIT = 1;  // capture frame: rx_space

    // Bit positions of the raw JTAG inputs inside the synchroniser vector.
    localparam int unsigned SYNC_TCK   = 0;
    localparam int unsigned SYNC_TDI   = 1;
    localparam int unsigned SYNC_SEL   = 2;
    localparam int unsigned SYNC_CAP   = 3;
    localparam int unsigned SYNC_SHIFT = 4;
    localparam int unsigned SYNC_UPD   = 5;
    localparam int unsigned SYNC_W     = 6;

    function automatic int unsigned frame_w(input int unsigned data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/sqrl_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pop_data reads 0 while empty.
// A push into a full FIFO is refused even when a pop happens the same cycle.
module sqrl_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sqrl_jtag_stream.sv
// Flow-controlled bidirectional word stream over one USER DR chain; the raw
// BSCANE2 signals are oversampled and all JTAG actions run in the clk domain.
module sqrl_jtag_stream
    import sqrl_jtag_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TX_DEPTH    = 16,
    parameter int unsigned RX_DEPTH    = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        jtag_tck,
    input  logic                        jtag_tdi,
    input  logic                        jtag_sel,
    input  logic                        jtag_capture,
    input  logic                        jtag_shift,
    input  logic                        jtag_update,
    output logic                        jtag_tdo,
    output logic [DATA_W-1:0]           rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    input  logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        rx_overflow,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic [$clog2(RX_DEPTH):0]   rx_level
);

    localparam int unsigned FW = frame_w(DATA_W);

    logic [SYNC_W-1:0] raw;
    logic [SYNC_W-1:0] synced;
    logic              tck_q;
    logic              tck_rise;
    logic              do_cap;
    logic              do_shift;
    logic              do_upd;
    logic [FW-1:0]     sr;
    logic [FW-1:0]     cap_frame;
    logic              cap_txv;
    logic              tdo_q;
    logic              overflow_q;
    logic [DATA_W-1:0] tx_head;
    logic              tx_full;
    logic              tx_empty;
    logic              tx_push;
    logic              tx_pop;
    logic              rx_full;
    logic              rx_empty;
    logic              rx_push;

    always_comb begin
        raw             = '0;
        raw[SYNC_TCK]   = jtag_tck;
        raw[SYNC_TDI]   = jtag_tdi;
        raw[SYNC_SEL]   = jtag_sel;
        raw[SYNC_CAP]   = jtag_capture;
        raw[SYNC_SHIFT] = jtag_shift;
        raw[SYNC_UPD]   = jtag_update;
    end

    for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
        logic [SYNC_W-1:0] q;
        if (s == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (!rstn) q <= '0;
                else       q <= raw;
            end
        end else begin : g_next
            always_ff @(posedge clk) begin
                if (!rstn) q <= '0;
                else       q <= g_sync[s-1].q;
            end
        end
    end
    assign synced = g_sync[SYNC_STAGES-1].q;

    // Capture/shift/update are mutually exclusive TAP states; priority only
    // guards against glitchy sampling.
    assign tck_rise = synced[SYNC_TCK] & ~tck_q;
    assign do_cap   = tck_rise & synced[SYNC_SEL] & synced[SYNC_CAP];
    assign do_shift = tck_rise & synced[SYNC_SEL] & synced[SYNC_SHIFT] & ~synced[SYNC_CAP];
    assign do_upd   = tck_rise & synced[SYNC_SEL] & synced[SYNC_UPD]
                    & ~synced[SYNC_CAP] & ~synced[SYNC_SHIFT];

    always_comb begin
        cap_frame                                     = '0;
        cap_frame[DATA_W-1:0]                         = tx_head;
        cap_frame[DATA_W + FRAME_STATUS_TXAVAIL_BIT]  = ~tx_empty;
        cap_frame[DATA_W + FRAME_STATUS_RXSPACE_BIT]  = ~rx_full;
    end

    assign tx_pop  = do_upd & sr[DATA_W + FRAME_ACK_BIT] & cap_txv;
    assign rx_push = do_upd & sr[DATA_W + FRAME_VALID_BIT];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tck_q      <= 1'b0;
            sr         <= '0;
            cap_txv    <= 1'b0;
            tdo_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            tck_q <= synced[SYNC_TCK];
            tdo_q <= sr[0];
            if (do_cap) begin
                sr      <= cap_frame;
                cap_txv <= ~tx_empty;
            end else if (do_shift) begin
                sr <= {synced[SYNC_TDI], sr[FW-1:1]};
            end else if (do_upd) begin
                cap_txv <= 1'b0;
                if (rx_push && rx_full) overflow_q <= 1'b1;
            end
        end
    end

    assign jtag_tdo    = tdo_q;
    assign rx_overflow = overflow_q;
    assign tx_ready    = rstn & ~tx_full;
    assign tx_push     = tx_valid & tx_ready;
    assign rx_valid    = ~rx_empty;

    sqrl_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (tx_push),
        .push_data (tx_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    sqrl_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (rx_push),
        .push_data (sr[DATA_W-1:0]),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

endmodule
